// File: rtl/i2c_seg_pkg.sv
// Shared types and constants for the write-only I2C segment-display master.
package i2c_seg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK_A,
        ST_DATA,
        ST_ACK_D,
        ST_STOP
    } state_e;

    localparam logic       RW_WRITE      = 1'b0;
    localparam logic [1:0] Q0            = 2'd0;
    localparam logic [1:0] Q1            = 2'd1;
    localparam logic [1:0] Q2            = 2'd2;
    localparam logic [1:0] Q3            = 2'd3;
    localparam int         BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period prescaler: one-cycle tick every CLK_DIV clocks, parked while clear_i is high.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int             CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear_i || cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0) && !clear_i;

endmodule

// File: rtl/i2c_segment_master_tx.sv
// Write-only I2C master: START, address+W, one data byte, STOP, with ACK checks.
// state    | meaning
// IDLE     | bus released, waiting for start
// START    | SDA low then SCL low (2 quarters)
// ADDR     | 8 address/RW bits, 4 quarters each
// ACK_A    | address ACK slot, sample SDA at end of Q2
// DATA     | 8 data bits
// ACK_D    | data ACK slot
// STOP     | SCL high, then SDA high, then bus free quarter
module i2c_segment_master_tx
    import i2c_seg_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe
);

    state_e     state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] data_q, data_d;
    logic       nack_q, nack_d;
    logic       done_q, done_d;
    logic       tick;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == ST_IDLE),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        sda_oe  = 1'b0;
        scl_oe  = 1'b0;
        busy    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_START;
                    sh_d    = {addr, RW_WRITE};
                    data_d  = data;
                    nack_d  = 1'b0;
                    qtr_d   = Q0;
                    bit_d   = 3'(BITS_PER_BYTE - 1);
                end
            end
            ST_START: begin
                sda_oe = 1'b1;
                scl_oe = (qtr_q != Q0);
                if (tick) begin
                    if (qtr_q == Q1) begin
                        state_d = ST_ADDR;
                        qtr_d   = Q0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                scl_oe = (qtr_q <= Q1);
                sda_oe = ~sh_q[7];
                if (tick) begin
                    if (qtr_q == Q3) begin
                        qtr_d = Q0;
                        sh_d  = {sh_q[6:0], 1'b0};
                        if (bit_q == 3'd0) begin
                            state_d = (state_q == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
                            bit_d   = 3'(BITS_PER_BYTE - 1);
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_ACK_A, ST_ACK_D: begin
                scl_oe = (qtr_q <= Q1);
                if (tick) begin
                    if (qtr_q == Q2 && sda_in) begin
                        nack_d = 1'b1;
                    end
                    if (qtr_q == Q3) begin
                        qtr_d = Q0;
                        // nack_q was cleared at acceptance, so here it reflects this slot only
                        if (nack_q || state_q == ST_ACK_D) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                            sh_d    = data_q;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                scl_oe = (qtr_q == Q0);
                sda_oe = (qtr_q <= Q1);
                if (tick) begin
                    if (qtr_q == Q3) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            qtr_q   <= Q0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
        end
    end

    assign nack = nack_q;
    assign done = done_q;

endmodule

// File: tb/tb_i2c_segment_master_tx.sv
// Bench for i2c_segment_master_tx: target model on the bus, vector table, scoreboard, protocol checks.
module tb_i2c_segment_master_tx;

    localparam int DIV      = 2;
    localparam int T_FULL   = 78 * DIV + 1;
    localparam int T_ANACK  = 42 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data = '0;
    logic       busy, done, nack, sda_in, sda_oe, scl_oe;

    i2c_segment_master_tx #(.CLK_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .addr   (addr),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .nack   (nack),
        .sda_in (sda_in),
        .sda_oe (sda_oe),
        .scl_oe (scl_oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- target model and bus protocol monitor ----------------
    logic       tgt_pull = 1'b0;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       pend = 1'b0, in_ack = 1'b0;
    logic [7:0] tsh = '0;
    int         bitn = 0, byten = 0;
    int         n_start = 0, n_stop = 0, done_cnt = 0;
    logic       ack_en [2];
    logic [7:0] rxq [$];

    assign sda_in = ~(sda_oe | tgt_pull);

    always @(negedge clk) begin
        logic scl_now, sda_now;
        scl_now = ~scl_oe;
        sda_now = ~(sda_oe | tgt_pull);
        if (done) done_cnt++;
        if (scl_p && scl_now && sda_p && !sda_now) begin
            n_start++;
            bitn = 0; byten = 0; pend = 1'b0; in_ack = 1'b0;
        end
        if (scl_p && scl_now && !sda_p && sda_now) n_stop++;
        if (!scl_p && scl_now && !in_ack) begin
            tsh = {tsh[6:0], sda_now};
            bitn++;
            if (bitn == 8) begin
                rxq.push_back(tsh);
                bitn = 0;
                pend = 1'b1;
            end
        end
        if (scl_p && !scl_now) begin
            if (pend) begin
                tgt_pull = (byten < 2) ? ack_en[byten] : 1'b0;
                in_ack = 1'b1;
                pend = 1'b0;
            end else if (in_ack) begin
                tgt_pull = 1'b0;
                in_ack = 1'b0;
                byten++;
            end
        end
        scl_p = scl_now;
        sda_p = ~(sda_oe | tgt_pull);
    end

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        logic       ack_a;
        logic       ack_d;
        logic       e_nack;
        int         e_cyc;
        int         e_bytes;
    } vec_t;

    vec_t vecs [6];
    vec_t exp_q [$];

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Entered and left at #1 after a posedge; the entry cycle is the acceptance cycle.
    task automatic run_xfer(input vec_t v, input bit hold, input string tag);
        vec_t e;
        int   cyc;
        ack_en[0] = v.ack_a;
        ack_en[1] = v.ack_d;
        rxq.delete();
        n_start = 0;
        n_stop  = 0;
        start = 1'b1;
        addr  = v.a;
        data  = v.d;
        exp_q.push_back(v);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_sda_c1"}, sda_oe, 1);
        chk({tag, "_nack_clr"}, nack, 0);
        if (hold) begin
            addr = ~v.a;
            data = ~v.d;
        end
        wait_done(cyc);
        e = exp_q.pop_front();
        chk({tag, "_done_cyc"}, cyc, e.e_cyc);
        chk({tag, "_nack"}, nack, e.e_nack);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_nbytes"}, rxq.size(), e.e_bytes);
        if (rxq.size() > 0) chk({tag, "_addr_byte"}, rxq[0], {e.a, 1'b0});
        if (rxq.size() > 1) chk({tag, "_data_byte"}, rxq[1], e.d);
        chk({tag, "_starts"}, n_start, 1);
        chk({tag, "_stops"}, n_stop, 1);
        chk({tag, "_released"}, {scl_oe, sda_oe}, 2'b00);
        if (!hold) begin
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_idle"}, busy, 0);
        end
    endtask

    initial begin
        int cyc;
        int dc;
        vec_t v;
        vecs[0] = '{7'h38, 8'h5B, 1'b1, 1'b1, 1'b0, T_FULL,  2};
        vecs[1] = '{7'h38, 8'h5B, 1'b0, 1'b1, 1'b1, T_ANACK, 1};
        vecs[2] = '{7'h38, 8'h5B, 1'b1, 1'b0, 1'b1, T_FULL,  2};
        vecs[3] = '{7'h7F, 8'hFF, 1'b1, 1'b1, 1'b0, T_FULL,  2};
        vecs[4] = '{7'h00, 8'h00, 1'b1, 1'b1, 1'b0, T_FULL,  2};
        vecs[5] = '{7'h55, 8'hA5, 1'b0, 1'b0, 1'b1, T_ANACK, 1};
        ack_en[0] = 1'b1;
        ack_en[1] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda", sda_oe, 0);
        chk("rst_scl", scl_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i], 1'b0, $sformatf("v%0d", i));
        end

        // back-to-back with start held and inputs scrambled after acceptance
        v = '{7'h21, 8'h3C, 1'b1, 1'b1, 1'b0, T_FULL, 2};
        run_xfer(v, 1'b1, "b2b0");
        v = '{7'h11, 8'h99, 1'b1, 1'b1, 1'b0, T_FULL, 2};
        run_xfer(v, 1'b0, "b2b1");

        // reset during DATA bit 3 (fourth data slot)
        ack_en[0] = 1'b1;
        ack_en[1] = 1'b1;
        start = 1'b1;
        addr  = 7'h38;
        data  = 8'h5B;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 104) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_mid_busy_before", busy, 1);
        dc = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_sda", sda_oe, 0);
        chk("rst_mid_scl", scl_oe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_nack", nack, 0);
        chk("rst_mid_done", done, 0);
        rst = 1'b0;
        tgt_pull = 1'b0;
        in_ack = 1'b0;
        pend = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt, dc);
        chk("rst_mid_idle", busy, 0);

        // bus recovers after abort
        @(posedge clk); #1;
        run_xfer(vecs[0], 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
